// File: rtl/fetch_unit.sv
// Instruction fetch unit: prefetch buffer, one-cycle-latency memory, epoch-tagged redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the misalign output and halts fetch on unaligned targets.
module fetch_unit #(
   parameter int              PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_rd_en,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            instr_ready,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_next
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign
`endif
);

   localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [PC_W-1:0] fetch_pc_reg;
   logic            inflight_reg;
   logic [PC_W-1:0] inflight_pc_reg;
   logic            inflight_epoch_reg;
   logic            epoch_reg;
   logic [CW-1:0]   count_reg;
   logic [AW-1:0]   head_reg;
   logic [AW-1:0]   tail_reg;
   logic [31:0]     instr_mem [BUF_DEPTH];
   logic [PC_W-1:0] pc_mem    [BUF_DEPTH];

   logic            halt;
   logic            pop;
   logic            write;
   logic            issue;
   logic [CW-1:0]   projected;
   logic [PC_W-1:0] target;

   assign instr_valid = (count_reg != '0);
   assign pop         = instr_valid & instr_ready & ~redirect;
   assign write       = inflight_reg & (inflight_epoch_reg == epoch_reg) & ~redirect;
   // The slot freed by this cycle's pop is credited so the pipeline sustains one word per cycle.
   assign projected   = count_reg + CW'(inflight_reg) - CW'(pop);
   assign issue       = rst & ~redirect & ~halt & (projected < CW'(BUF_DEPTH));

   assign imem_rd_en  = issue;
   assign imem_addr   = fetch_pc_reg;
   assign instr       = instr_valid ? instr_mem[head_reg] : '0;
   assign pc          = instr_valid ? pc_mem[head_reg] : fetch_pc_reg;
   assign pc_next     = pc + PC_W'(4);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_reg       <= RESET_PC;
         inflight_reg       <= 1'b0;
         inflight_pc_reg    <= RESET_PC;
         inflight_epoch_reg <= 1'b0;
         epoch_reg          <= 1'b0;
         count_reg          <= '0;
         head_reg           <= '0;
         tail_reg           <= '0;
      end else begin
         epoch_reg          <= epoch_reg ^ redirect;
         inflight_reg       <= issue;
         inflight_pc_reg    <= fetch_pc_reg;
         inflight_epoch_reg <= epoch_reg;
         if (redirect) begin
            fetch_pc_reg <= target;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
         end else begin
            if (issue) fetch_pc_reg <= fetch_pc_reg + PC_W'(4);
            count_reg <= count_reg + CW'(write) - CW'(pop);
            if (write) tail_reg <= tail_reg + AW'(1);
            if (pop)   head_reg <= head_reg + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (write) begin
         instr_mem[tail_reg] <= imem_rdata;
         pc_mem[tail_reg]    <= inflight_pc_reg;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halt_reg;
   logic misalign_reg;

   assign target   = redirect_pc;
   assign halt     = halt_reg;
   assign misalign = misalign_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_reg     <= 1'b0;
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= redirect & (redirect_pc[1:0] != 2'b00);
         if (redirect) halt_reg <= (redirect_pc[1:0] != 2'b00);
      end
   end
`else
   assign target = redirect_pc & ~PC_W'(3);
   assign halt   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus random traffic checked against a queue-based fetch model.
// Honors FETCH_MISALIGN_TRAP_EN when defined.
module tb_fetch_unit;
   localparam int          DEPTH  = 2;
   localparam logic [15:0] RST_PC = 16'h0000;

   typedef struct {
      logic [15:0] a;
      int          c;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        rd_en;
   logic [31:0] rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        ready;
   logic        valid;
   logic [31:0] instr;
   logic [15:0] pc;
   logic [15:0] pc_next;
   logic [7:0]  addr2;
   logic        rd_en2;
   logic [31:0] rdata2;
   logic        valid2;
   logic [31:0] instr2;
   logic [7:0]  pc2;
   logic [7:0]  pc_next2;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
   logic        misalign2;
`endif

   int          vecs = 0;
   int          errs = 0;
   int          cyc  = 0;
   ent_t        q[$];
   logic [15:0] mfetch;
   logic        mhalt;
   logic        mis_exp;

   always #5 clk = ~clk;

   // Instruction memory: word equals its address, one-cycle read latency.
   always @(posedge clk) rdata  <= rd_en  ? 32'(addr)  : 32'hDEAD_BEEF;
   always @(posedge clk) rdata2 <= rd_en2 ? 32'(addr2) : 32'hDEAD_BEEF;

   fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .imem_addr(addr), .imem_rd_en(rd_en), .imem_rdata(rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .instr_ready(ready),
      .instr_valid(valid), .instr(instr), .pc(pc), .pc_next(pc_next)
`ifdef FETCH_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   fetch_unit #(.PC_W(8), .RESET_PC(8'hFC), .BUF_DEPTH(4)) dut2 (
      .clk(clk), .rst(rst), .imem_addr(addr2), .imem_rd_en(rd_en2), .imem_rdata(rdata2),
      .redirect(1'b0), .redirect_pc(8'h00), .instr_ready(1'b1),
      .instr_valid(valid2), .instr(instr2), .pc(pc2), .pc_next(pc_next2)
`ifdef FETCH_MISALIGN_TRAP_EN
      , .misalign(misalign2)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      q.delete();
      mfetch  = RST_PC;
      mhalt   = 1'b0;
      mis_exp = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rd_en", 64'(rd_en), 64'(0));
      chk("rst_addr", 64'(addr), 64'(RST_PC));
      chk("rst_valid", 64'(valid), 64'(0));
      chk("rst_instr", 64'(instr), 64'(0));
      chk("rst_pc", 64'(pc), 64'(RST_PC));
      chk("rst_pc_next", 64'(pc_next), 64'(16'(RST_PC + 16'd4)));
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then apply the coming edge to the model.
   task automatic run(input logic r, input logic rdy, input logic rdr, input logic [15:0] tgt);
      logic exp_valid;
      logic exp_rd;
      logic xfer;
      @(negedge clk);
      rst         = r;
      ready       = rdy;
      redirect    = rdr;
      redirect_pc = tgt;
      #1;
      if (!r) begin
         chk_reset_outputs();
         model_reset();
         cyc++;
         return;
      end
      exp_valid = (q.size() > 0) && (q[0].c <= cyc - 2);
      chk("valid", 64'(valid), 64'(exp_valid));
      if (exp_valid) begin
         chk("pc", 64'(pc), 64'(q[0].a));
         chk("instr", 64'(instr), 64'(32'(q[0].a)));
         chk("pc_next", 64'(pc_next), 64'(16'(q[0].a + 16'd4)));
      end
      xfer   = exp_valid && rdy && !rdr;
      exp_rd = !rdr && !mhalt && ((q.size() - int'(xfer)) < DEPTH);
      chk("rd_en", 64'(rd_en), 64'(exp_rd));
      if (exp_rd) chk("addr", 64'(addr), 64'(mfetch));
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("misalign", 64'(misalign), 64'(mis_exp));
`endif
      mis_exp = 1'b0;
      if (rdr) begin
         q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
         mfetch  = tgt;
         mis_exp = (tgt[1:0] != 2'b00);
         mhalt   = mis_exp;
`else
         mfetch  = tgt & 16'hFFFC;
`endif
      end else begin
         if (xfer) void'(q.pop_front());
         if (exp_rd) begin
            q.push_back('{a: mfetch, c: cyc});
            mfetch = mfetch + 16'd4;
         end
      end
      cyc++;
   endtask

   // Stream with ready=1 until the first valid word; it must carry the given pc.
   task automatic expect_first(input string tag, input logic [15:0] exp_pc);
      logic found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         run(1'b1, 1'b1, 1'b0, 16'h0);
         if (valid) begin
            found = 1'b1;
            chk({tag, "_pc"}, 64'(pc), 64'(exp_pc));
            chk({tag, "_pc_next"}, 64'(pc_next), 64'(16'(exp_pc + 16'd4)));
         end
      end
      chk({tag, "_seen"}, 64'(found), 64'(1));
   endtask

   initial begin
      int          rd_cnt;
      logic        rdy;
      logic        rdr;
      logic [15:0] tgt;
      rst = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      model_reset();

      // Reset values, both instances.
      for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b0, 16'h0);
      chk("rst2_pc", 64'(pc2), 64'(8'hFC));
      chk("rst2_pc_next", 64'(pc_next2), 64'(8'h00));

      // Warm-up stream from reset; the 8-bit instance wraps from 0xFC to 0x00.
      for (int k = 0; k < 10; k++) begin
         run(1'b1, 1'b1, 1'b0, 16'h0);
         if (k >= 2) begin
            chk("w2_valid", 64'(valid2), 64'(1));
            chk("w2_pc", 64'(pc2), 64'(8'(8'hFC + 8'(4 * (k - 2)))));
            chk("w2_pc_next", 64'(pc_next2), 64'(8'(8'h00 + 8'(4 * (k - 2)))));
            chk("w2_instr", 64'(instr2), 64'(32'(8'(8'hFC + 8'(4 * (k - 2))))));
         end else begin
            chk("w2_valid", 64'(valid2), 64'(0));
         end
      end

      // Stalled decode: only DEPTH reads may issue, head holds pc 0.
      run(1'b0, 1'b0, 1'b0, 16'h0);
      rd_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         run(1'b1, 1'b0, 1'b0, 16'h0);
         rd_cnt += int'(rd_en);
      end
      chk("stall_reads", 64'(rd_cnt), 64'(DEPTH));
      chk("stall_pc", 64'(pc), 64'(0));

      // Redirect with a read in flight.
      for (int k = 0; k < 5; k++) run(1'b1, 1'b1, 1'b0, 16'h0);
      run(1'b1, 1'b1, 1'b1, 16'h0040);
      expect_first("redir40", 16'h0040);

      // Back-to-back redirects: only the last target survives.
      run(1'b1, 1'b1, 1'b1, 16'h0100);
      run(1'b1, 1'b1, 1'b1, 16'h0200);
      expect_first("b2b", 16'h0200);

      // Unaligned redirect target.
      run(1'b1, 1'b1, 1'b1, 16'h0042);
`ifdef FETCH_MISALIGN_TRAP_EN
      rd_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         run(1'b1, 1'b1, 1'b0, 16'h0);
         if (k == 0) chk("misalign_pulse", 64'(misalign), 64'(1));
         rd_cnt += int'(rd_en);
      end
      chk("misalign_no_reads", 64'(rd_cnt), 64'(0));
      run(1'b1, 1'b1, 1'b1, 16'h0080);
      expect_first("realign", 16'h0080);
`else
      expect_first("align42", 16'h0040);
`endif

      // Random traffic with one asynchronous reset between clock edges.
      for (int i = 0; i < 400; i++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rdr = ($urandom_range(0, 19) == 0);
         tgt = 16'($urandom);
`ifdef FETCH_MISALIGN_TRAP_EN
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
`endif
         if (i == 200) begin
            #2;
            rst = 1'b0;
            #1;
            chk_reset_outputs();
            chk("mid_rst2_pc", 64'(pc2), 64'(8'hFC));
            model_reset();
            run(1'b0, 1'b0, 1'b0, 16'h0);
         end
         run(1'b1, rdy, rdr, tgt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
